lorenz_frame_packer: RTL and testbench

LORENZ_FRAME_PACKER -- requirements
Module: lorenz_frame_packer

---
 rtl/lorenz_frame_packer.sv | 189 ++++++++++++++++++
 tb/tb_lorenz_frame_packer.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lorenz_frame_packer.sv
// -----------------------------------------------------------------------------
// lorenz_frame_packer
//
// Decimates the {x,y,z} state-vector stream of a Lorenz integrator, buffers
// the kept triples in a small FIFO, and serialises each triple as a 4-word
// frame on a valid/ready output:
//     HDR = {8'hA5, seq[7:0]},  X,  Y,  Z (out_last=1 on Z)
//
// Ports
//   clk        : single clock, rising edge
//   rst        : asynchronous, active-low reset
//   in_valid   : upstream presents a new step on x/y/z
//   x, y, z    : state-vector words (raw bits)
//   decim      : keep one step in every decim+1 valid steps (evaluated live)
//   out_data   : current frame word (registered)
//   out_valid  : out_data is valid (registered)
//   out_ready  : downstream accepts the word
//   out_last   : high on the Z word of each frame (registered)
//   overflow   : sticky, set when a kept triple is dropped on a full FIFO
// -----------------------------------------------------------------------------
module lorenz_frame_packer #(
    parameter int BITLENGTH = 16,
    parameter int DEPTH     = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic [BITLENGTH-1:0] x,
    input  logic [BITLENGTH-1:0] y,
    input  logic [BITLENGTH-1:0] z,
    input  logic [7:0]           decim,
    output logic [BITLENGTH-1:0] out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_last,
    output logic                 overflow
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        HDR  = 3'd1,
        WX   = 3'd2,
        WY   = 3'd3,
        WZ   = 3'd4
    } state_t;

    state_t               state_reg;
    logic [7:0]           dcnt_reg;
    logic [7:0]           seq_reg;
    logic [AW-1:0]        wr_ptr_reg;
    logic [AW-1:0]        rd_ptr_reg;
    logic [AW:0]          count_reg;

    logic [BITLENGTH-1:0] mem_x [DEPTH];
    logic [BITLENGTH-1:0] mem_y [DEPTH];
    logic [BITLENGTH-1:0] mem_z [DEPTH];

    logic capture;
    logic fifo_full;
    logic fifo_empty;
    logic pop;
    logic push;
    logic drop;
    logic more_after_pop;

    assign capture    = in_valid && (dcnt_reg >= decim);
    assign fifo_full  = (count_reg == (AW+1)'(DEPTH));
    assign fifo_empty = (count_reg == '0);
    // out_valid is always 1 in WZ, so an accepted Z word is WZ && out_ready.
    assign pop        = (state_reg == WZ) && out_ready;
    // A pop in the same cycle frees the slot the capture needs.
    assign push       = capture && (!fifo_full || pop);
    assign drop       = capture && fifo_full && !pop;
    // Entries left once the head is popped, counting a same-cycle push.
    assign more_after_pop = (count_reg > (AW+1)'(1)) || push;

    // -------------------------------------------------------------------------
    // Decimation counter and sticky overflow
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dcnt_reg <= 8'd0;
            overflow <= 1'b0;
        end else begin
            if (in_valid) begin
                // Dropped captures still restart the decimation window.
                if (capture) dcnt_reg <= 8'd0;
                else         dcnt_reg <= dcnt_reg + 8'd1;
            end
            if (drop) overflow <= 1'b1;
        end
    end

    // -------------------------------------------------------------------------
    // FIFO storage: no reset needed, validity is tracked by the pointers.
    // When full with a simultaneous pop, wr_ptr equals rd_ptr; the head being
    // overwritten is the one whose Z word is leaving on this very edge.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (push) begin
            mem_x[wr_ptr_reg] <= x;
            mem_y[wr_ptr_reg] <= y;
            mem_z[wr_ptr_reg] <= z;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
            if (pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
            case ({push, pop})
                2'b10:   count_reg <= count_reg + (AW+1)'(1);
                2'b01:   count_reg <= count_reg - (AW+1)'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Output FSM with registered outputs. The word for the next state is
    // loaded on the same edge the state advances.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
            seq_reg   <= 8'd0;
            out_data  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (!fifo_empty) begin
                        state_reg <= HDR;
                        out_data  <= {8'hA5, seq_reg};
                        out_valid <= 1'b1;
                        out_last  <= 1'b0;
                    end
                end
                HDR: begin
                    if (out_ready) begin
                        state_reg <= WX;
                        out_data  <= mem_x[rd_ptr_reg];
                    end
                end
                WX: begin
                    if (out_ready) begin
                        state_reg <= WY;
                        out_data  <= mem_y[rd_ptr_reg];
                    end
                end
                WY: begin
                    if (out_ready) begin
                        state_reg <= WZ;
                        out_data  <= mem_z[rd_ptr_reg];
                        out_last  <= 1'b1;
                    end
                end
                WZ: begin
                    if (out_ready) begin
                        seq_reg  <= seq_reg + 8'd1;
                        out_last <= 1'b0;
                        if (more_after_pop) begin
                            state_reg <= HDR;
                            out_data  <= {8'hA5, seq_reg + 8'd1};
                        end else begin
                            state_reg <= IDLE;
                            out_data  <= '0;
                            out_valid <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    out_data  <= '0;
                    out_valid <= 1'b0;
                    out_last  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lorenz_frame_packer.sv
// -----------------------------------------------------------------------------
// Testbench for lorenz_frame_packer.
// Inputs are driven 1 time unit after each rising edge; a checker on the
// falling edge compares the DUT against a queue-based model of the stream.
// -----------------------------------------------------------------------------
module tb_lorenz_frame_packer;

    localparam int DEPTH = 4;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [15:0] x, y, z;
    logic [7:0]  decim;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;
    logic        overflow;

    lorenz_frame_packer #(.BITLENGTH(16), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .x         (x),
        .y         (y),
        .z         (z),
        .decim     (decim),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Expected word idx (0..3) of a frame with sequence number seqv and step s.
    function automatic logic [15:0] exp_word(input int seqv, input int s, input int idx);
        case (idx)
            0:       return {8'hA5, 8'(seqv)};
            1:       return 16'(s);
            2:       return 16'(256 + s);
            default: return 16'(512 + s);
        endcase
    endfunction

    // ---------------- model state (checker process) ----------------
    logic [47:0] mq[$];           // kept triples {x,y,z} not yet fully sent
    int          mdcnt;
    logic [7:0]  mseq;
    int          midx;            // word index within the frame at the head
    logic        movf;
    logic        prev_stall;
    logic [15:0] prev_data;
    int          cyc;
    logic [15:0] acc_word[$];
    logic        acc_last[$];
    int          acc_cyc[$];
    int          cap_cyc[$];

    always @(negedge clk) begin
        logic [15:0] expw;
        logic        pop;
        cyc++;
        if (!rst) begin
            chk("rst_out_data", 32'(out_data), 32'd0);
            chk("rst_out_valid", 32'(out_valid), 32'd0);
            chk("rst_out_last", 32'(out_last), 32'd0);
            chk("rst_overflow", 32'(overflow), 32'd0);
            mq.delete();
            mdcnt = 0; mseq = 8'd0; midx = 0; movf = 1'b0; prev_stall = 1'b0;
            acc_word.delete(); acc_last.delete(); acc_cyc.delete(); cap_cyc.delete();
        end else begin
            if (prev_stall) begin
                chk("hold_valid", 32'(out_valid), 32'd1);
                chk("hold_data", 32'(out_data), 32'(prev_data));
            end
            chk("overflow", 32'(overflow), 32'(movf));
            pop = 1'b0;
            if (mq.size() == 0) begin
                chk("valid_when_empty", 32'(out_valid), 32'd0);
            end else if (out_valid) begin
                case (midx)
                    0:       expw = {8'hA5, mseq};
                    1:       expw = mq[0][47:32];
                    2:       expw = mq[0][31:16];
                    default: expw = mq[0][15:0];
                endcase
                chk("word", 32'(out_data), 32'(expw));
                chk("last", 32'(out_last), 32'(midx == 3));
                if (out_ready) begin
                    $display("word t=%0d data=%h last=%b", cyc, out_data, out_last);
                    acc_word.push_back(out_data);
                    acc_last.push_back(out_last);
                    acc_cyc.push_back(cyc);
                    if (midx == 3) pop = 1'b1;
                    midx = (midx + 1) % 4;
                end
            end else begin
                chk("last_idle", 32'(out_last), 32'd0);
            end
            if (in_valid) begin
                if (mdcnt >= int'(decim)) begin
                    cap_cyc.push_back(cyc);
                    if (mq.size() < DEPTH || pop) mq.push_back({x, y, z});
                    else                          movf = 1'b1;
                    mdcnt = 0;
                end else begin
                    mdcnt++;
                end
            end
            if (pop) begin
                void'(mq.pop_front());
                mseq = mseq + 8'd1;
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
        end
    end

    // ---------------- stimulus helpers ----------------
    logic toggle = 1'b0;

    task automatic step(input logic iv, input logic [15:0] sx, input logic [15:0] sy,
                        input logic [15:0] sz);
        @(posedge clk); #1;
        in_valid = iv; x = sx; y = sy; z = sz;
        if (toggle) out_ready = ~out_ready;
    endtask

    task automatic feed(input int s);
        step(1'b1, 16'(s), 16'(256 + s), 16'(512 + s));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 16'd0, 16'd0, 16'd0);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b0; in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    // Compare the accepted-word log against whole frames of the given steps.
    task automatic check_log(input string tag, input int steps[$], input int seq0);
        chk({tag, "_count"}, 32'(acc_word.size()), 32'(4 * steps.size()));
        for (int i = 0; i < acc_word.size() && i < 4 * steps.size(); i++) begin
            chk($sformatf("%s_w%0d", tag, i), 32'(acc_word[i]),
                32'(exp_word((seq0 + i / 4) % 256, steps[i / 4], i % 4)));
            chk($sformatf("%s_l%0d", tag, i), 32'(acc_last[i]), 32'(i % 4 == 3));
        end
    endtask

    initial begin
        int sq[$];
        rst = 1'b1; in_valid = 1'b0; x = '0; y = '0; z = '0;
        decim = 8'd0; out_ready = 1'b1;
        cyc = 0;

        // T1: single step, decim=0 -> A500 0002 0003 8003 on 4 consecutive cycles.
        do_reset();
        decim = 8'd0; out_ready = 1'b1;
        step(1'b1, 16'h0002, 16'h0003, 16'h8003);
        idle(10);
        chk("t1_count", 32'(acc_word.size()), 32'd4);
        if (acc_word.size() == 4 && cap_cyc.size() == 1) begin
            chk("t1_w0", 32'(acc_word[0]), 32'h0000A500);
            chk("t1_w1", 32'(acc_word[1]), 32'h00000002);
            chk("t1_w2", 32'(acc_word[2]), 32'h00000003);
            chk("t1_w3", 32'(acc_word[3]), 32'h00008003);
            chk("t1_last", 32'({acc_last[0], acc_last[1], acc_last[2], acc_last[3]}), 32'b0001);
            chk("t1_latency", 32'(acc_cyc[0]), 32'(cap_cyc[0] + 2));
            chk("t1_consec", 32'(acc_cyc[3]), 32'(acc_cyc[0] + 3));
        end

        // T2: decim=2, 9 steps -> frames for steps 3, 6, 9, back to back.
        do_reset();
        decim = 8'd2; out_ready = 1'b1;
        for (int s = 1; s <= 9; s++) feed(s);
        idle(12);
        sq = '{3, 6, 9};
        check_log("t2", sq, 0);
        if (acc_word.size() == 12) begin
            chk("t2_hdr0", 32'(acc_word[0]), 32'h0000A500);
            chk("t2_hdr1", 32'(acc_word[4]), 32'h0000A501);
            chk("t2_hdr2", 32'(acc_word[8]), 32'h0000A502);
            chk("t2_x1", 32'(acc_word[5]), 32'h00000006);
            chk("t2_no_bubble", 32'(acc_cyc[11]), 32'(acc_cyc[0] + 11));
        end

        // T3: out_ready=0, 5 captures into DEPTH=4 -> overflow, step 5 lost.
        do_reset();
        decim = 8'd0; out_ready = 1'b0;
        for (int s = 1; s <= 5; s++) feed(s);
        idle(3);
        chk("t3_overflow", 32'(overflow), 32'd1);
        chk("t3_none_sent", 32'(acc_word.size()), 32'd0);
        out_ready = 1'b1;
        idle(25);
        sq = '{1, 2, 3, 4};
        check_log("t3", sq, 0);
        chk("t3_overflow_sticky", 32'(overflow), 32'd1);

        // T4: out_ready toggling every cycle.
        do_reset();
        decim = 8'd0; out_ready = 1'b0; toggle = 1'b1;
        feed(10); idle(2); feed(20); idle(2); feed(30);
        idle(40);
        toggle = 1'b0; out_ready = 1'b1;
        sq = '{10, 20, 30};
        check_log("t4", sq, 0);

        // T5: full FIFO, Z word accepted on the same edge as a capture.
        do_reset();
        decim = 8'd0; out_ready = 1'b0;
        for (int s = 1; s <= 4; s++) feed(s);
        idle(3);
        out_ready = 1'b1;
        idle(2);          // HDR, X, Y accepted on the next three edges
        feed(5);          // sampled on the edge that accepts Z
        idle(30);
        chk("t5_overflow", 32'(overflow), 32'd0);
        if (acc_cyc.size() > 3 && cap_cyc.size() == 5)
            chk("t5_same_edge", 32'(acc_cyc[3]), 32'(cap_cyc[4]));
        sq = '{1, 2, 3, 4, 5};
        check_log("t5", sq, 0);

        // T6: reset during WY, then 257 frames to see the sequence wrap.
        do_reset();
        decim = 8'd0; out_ready = 1'b1;
        feed(7);
        idle(4);
        chk("t6_in_wy", 32'(out_data), 32'h00000107);
        rst = 1'b0;
        #2;
        chk("t6_async_data", 32'(out_data), 32'd0);
        chk("t6_async_valid", 32'(out_valid), 32'd0);
        chk("t6_async_last", 32'(out_last), 32'd0);
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b1;        // released together with a valid step
        in_valid = 1'b1; x = 16'd0; y = 16'd256; z = 16'd512;
        idle(3);
        for (int s = 1; s <= 256; s++) begin
            feed(s);
            idle(3);
        end
        idle(10);
        sq.delete();
        for (int s = 0; s <= 256; s++) sq.push_back(s);
        check_log("t6", sq, 0);
        if (acc_word.size() == 4 * 257 && cap_cyc.size() == 257) begin
            chk("t6_first_hdr", 32'(acc_word[0]), 32'h0000A500);
            chk("t6_first_edge", 32'(acc_cyc[0]), 32'(cap_cyc[0] + 2));
            chk("t6_hdr_ff", 32'(acc_word[4 * 255]), 32'h0000A5FF);
            chk("t6_hdr_wrap", 32'(acc_word[4 * 256]), 32'h0000A500);
        end
        chk("t6_overflow", 32'(overflow), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
